// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 16-bit asynchronous SRAM port between instruction
// fetch (the default owner) and MEM-stage loads/stores. A data access
// preempts fetch, stalls the PC, and runs a fixed-timing read or write
// sequence on the SRAM pins.
module mem_arbiter #(
    parameter int unsigned        ADDR_W    = 18,
    parameter int unsigned        WR_CYCLES = 2,
    parameter logic [ADDR_W-17:0] DATA_PAGE = 2'b01,
    parameter logic [15:0]        NOP_INSTR = 16'h0800
) (
    input  logic              CLK,
    input  logic              RST,
    // instruction fetch side
    input  logic [15:0]       if_addr_i,
    output logic [15:0]       if_instr_o,
    output logic              if_valid_o,
    output logic              stall_pc_o,
    // MEM-stage load/store side
    input  logic              mem_rd_i,
    input  logic              mem_wr_i,
    input  logic [15:0]       mem_addr_i,
    input  logic [15:0]       mem_wdata_i,
    output logic [15:0]       mem_rdata_o,
    output logic              mem_done_o,
    // SRAM pins
    output logic [ADDR_W-1:0] sram_addr_o,
    inout  wire  [15:0]       sram_data_io,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o
);

    localparam int CNT_W = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DREAD,
        S_WSETUP,
        S_WPULSE,
        S_WHOLD
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_next_cnt;

    logic [15:0]        r_addr_q;
    logic [15:0]        r_wdata_q;
    logic [15:0]        r_instr;
    logic               r_valid;
    logic [15:0]        r_rdata;
    logic               r_done;

    logic               w_accept;
    logic [ADDR_W-1:0]  w_sram_addr;
    logic               w_oe_n;
    logic               w_we_n;
    logic               w_drive;

    // A data request is taken only from FETCH, and never in the done cycle,
    // so back-to-back accesses always leave one fetch cycle between them.
    assign w_accept   = (r_state == S_FETCH) & (mem_rd_i | mem_wr_i) & ~r_done;
    assign stall_pc_o = (r_state != S_FETCH) | w_accept;

    // State register and write-pulse counter.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Next-state logic; stores win over loads when both are requested.
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_FETCH: begin
                if (w_accept) begin
                    w_next_state = mem_wr_i ? S_WSETUP : S_DREAD;
                end
            end
            S_DREAD: begin
                w_next_state = S_FETCH;
            end
            S_WSETUP: begin
                w_next_state = S_WPULSE;
                w_next_cnt   = CNT_W'(WR_CYCLES - 1);
            end
            S_WPULSE: begin
                if (r_cnt == '0) begin
                    w_next_state = S_WHOLD;
                end else begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                end
            end
            S_WHOLD: begin
                w_next_state = S_FETCH;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    // SRAM pin values implied by the current state.
    always_comb begin
        w_sram_addr = {{(ADDR_W-16){1'b0}}, if_addr_i};
        w_oe_n      = 1'b1;
        w_we_n      = 1'b1;
        w_drive     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_oe_n = 1'b0;
            end
            S_DREAD: begin
                w_sram_addr = {DATA_PAGE, r_addr_q};
                w_oe_n      = 1'b0;
            end
            S_WSETUP: begin
                w_sram_addr = {DATA_PAGE, r_addr_q};
                w_drive     = 1'b1;
            end
            S_WPULSE: begin
                w_sram_addr = {DATA_PAGE, r_addr_q};
                w_we_n      = 1'b0;
                w_drive     = 1'b1;
            end
            S_WHOLD: begin
                w_sram_addr = {DATA_PAGE, r_addr_q};
                w_drive     = 1'b1;
            end
            default: begin
                w_oe_n = 1'b1;
            end
        endcase
    end

    // Reset gates the strobes and the bus directly, so an in-flight write
    // pulse is cut in the same cycle reset is asserted.
    assign sram_addr_o  = w_sram_addr;
    assign sram_ce_n_o  = ~RST;
    assign sram_oe_n_o  = w_oe_n | ~RST;
    assign sram_we_n_o  = w_we_n | ~RST;
    assign sram_data_io = (w_drive & RST) ? r_wdata_q : 16'hzzzz;

    // Request capture, fetch/load data registers and the completion pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_addr_q  <= '0;
            r_wdata_q <= '0;
            r_instr   <= NOP_INSTR;
            r_valid   <= 1'b0;
            r_rdata   <= '0;
            r_done    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr_q  <= mem_addr_i;
                r_wdata_q <= mem_wdata_i;
            end

            r_done <= (r_state == S_DREAD) | (r_state == S_WHOLD);

            if (r_state == S_DREAD) begin
                r_rdata <= sram_data_io;
            end

            if (r_state == S_FETCH) begin
                if (w_accept) begin
                    r_valid <= 1'b0;
                    r_instr <= NOP_INSTR;
                end else begin
                    r_valid <= 1'b1;
                    r_instr <= sram_data_io;
                end
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign if_instr_o  = r_instr;
    assign if_valid_o  = r_valid;
    assign mem_rdata_o = r_rdata;
    assign mem_done_o  = r_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a behavioural SRAM on the pins, a
// word-level expected-memory model, fixed-latency transaction checks,
// table-driven vectors, hand-written corner sequences and random traffic.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 18;
    localparam int unsigned WR     = 2;
    localparam logic [1:0]  PAGE   = 2'b01;
    localparam logic [15:0] NOP    = 16'h0800;

    logic              CLK = 1'b0;
    logic              RST;
    logic [15:0]       if_addr_i;
    logic [15:0]       if_instr_o;
    logic              if_valid_o;
    logic              stall_pc_o;
    logic              mem_rd_i;
    logic              mem_wr_i;
    logic [15:0]       mem_addr_i;
    logic [15:0]       mem_wdata_i;
    logic [15:0]       mem_rdata_o;
    logic              mem_done_o;
    logic [ADDR_W-1:0] sram_addr_o;
    wire  [15:0]       sram_data_io;
    logic              sram_ce_n_o;
    logic              sram_oe_n_o;
    logic              sram_we_n_o;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .WR_CYCLES (WR),
        .DATA_PAGE (PAGE),
        .NOP_INSTR (NOP)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .if_addr_i    (if_addr_i),
        .if_instr_o   (if_instr_o),
        .if_valid_o   (if_valid_o),
        .stall_pc_o   (stall_pc_o),
        .mem_rd_i     (mem_rd_i),
        .mem_wr_i     (mem_wr_i),
        .mem_addr_i   (mem_addr_i),
        .mem_wdata_i  (mem_wdata_i),
        .mem_rdata_o  (mem_rdata_o),
        .mem_done_o   (mem_done_o),
        .sram_addr_o  (sram_addr_o),
        .sram_data_io (sram_data_io),
        .sram_ce_n_o  (sram_ce_n_o),
        .sram_oe_n_o  (sram_oe_n_o),
        .sram_we_n_o  (sram_we_n_o)
    );

    // Pin-level SRAM: drives the bus on a read, stores on a clocked we_n low.
    logic [15:0] sram_mem [0:(1<<ADDR_W)-1];
    logic        probe_en = 1'b0;

    assign sram_data_io = (!sram_ce_n_o && !sram_oe_n_o && sram_we_n_o)
                          ? sram_mem[sram_addr_o] : 16'hzzzz;
    // Weak-intent probe: drives zero while the DUT must leave the bus alone.
    assign sram_data_io = probe_en ? 16'h0000 : 16'hzzzz;

    always @(posedge CLK) begin
        if (!sram_ce_n_o && !sram_we_n_o) sram_mem[sram_addr_o] <= sram_data_io;
    end

    // Expected memory contents, maintained at transaction level.
    logic [15:0] exp_written [logic [17:0]];

    function automatic logic [15:0] init_word(input logic [17:0] a);
        return a[15:0] ^ {6'h00, a[17:16], 8'h00} ^ 16'h3C5A;
    endfunction

    function automatic logic [15:0] exp_word(input logic [17:0] a);
        if (exp_written.exists(a)) return exp_written[a];
        return init_word(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic preload(input logic [17:0] a, input logic [15:0] w);
        sram_mem[a]    = w;
        exp_written[a] = w;
    endtask

    // One data access with fixed-latency expectations: load done at t+2,
    // store done at t+3+WR with we_n low in t+2..t+1+WR. The done cycle also
    // presents fetch address faddr, whose word must appear the cycle after.
    task automatic do_txn(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] faddr);
        int          total;
        logic [17:0] daddr;
        logic [15:0] load_exp;
        daddr    = {PAGE, addr};
        load_exp = exp_word(daddr);
        total    = wr ? (3 + WR) : 2;

        @(negedge CLK);
        mem_rd_i    = rd;
        mem_wr_i    = wr;
        mem_addr_i  = addr;
        mem_wdata_i = wdata;
        #1;
        check("accept_stall", stall_pc_o, 1);
        check("accept_done_low", mem_done_o, 0);

        for (int k = 1; k <= total; k++) begin
            @(negedge CLK);
            if (k == total) begin
                mem_rd_i  = 1'b0;
                mem_wr_i  = 1'b0;
                if_addr_i = faddr;
            end
            #1;
            check("txn_done", mem_done_o, (k == total));
            check("txn_stall", stall_pc_o, (k != total));
            check("txn_valid_low", if_valid_o, 0);
            if (wr) begin
                check("wr_we_n", sram_we_n_o, !(k >= 2 && k <= 1 + WR));
                if (k < total) begin
                    check("wr_oe_n", sram_oe_n_o, 1);
                    check("wr_addr", sram_addr_o, daddr);
                    check("wr_bus", sram_data_io, wdata);
                end
            end else if (k == 1) begin
                check("rd_oe_n", sram_oe_n_o, 0);
                check("rd_addr", sram_addr_o, daddr);
                check("rd_we_n", sram_we_n_o, 1);
            end
            if (k == total) begin
                check("done_instr_nop", if_instr_o, NOP);
                if (wr) begin
                    exp_written[daddr] = wdata;
                    check("wr_sram_word", sram_mem[daddr], wdata);
                end else begin
                    check("rd_data", mem_rdata_o, load_exp);
                end
            end
        end

        @(negedge CLK);
        #1;
        check("post_fetch_valid", if_valid_o, 1);
        check("post_fetch_instr", if_instr_o, exp_word({2'b00, faddr}));
        check("post_done_low", mem_done_o, 0);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [15:0] word;
    } fetch_vec_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] faddr;
    } txn_vec_t;

    fetch_vec_t fv [6];
    txn_vec_t   tv [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] b2b_addr [3];

        for (int i = 0; i < (1 << ADDR_W); i++) sram_mem[i] = init_word(18'(i));

        fv[0] = '{16'h0010, 16'h4A05};
        fv[1] = '{16'h0000, 16'h1234};
        fv[2] = '{16'hFFFF, 16'hABCD};
        fv[3] = '{16'h7FFF, 16'h0F0F};
        fv[4] = '{16'h8000, 16'hC3C3};
        fv[5] = '{16'h0011, 16'h0001};
        foreach (fv[i]) preload({2'b00, fv[i].addr}, fv[i].word);
        preload(18'h18000, 16'hBEEF);

        tv[0] = '{1'b1, 1'b0, 16'h8000, 16'h0000, 16'h0010};
        tv[1] = '{1'b0, 1'b1, 16'h0123, 16'h5A5A, 16'h0000};
        tv[2] = '{1'b1, 1'b0, 16'h0123, 16'h0000, 16'hFFFF};
        tv[3] = '{1'b1, 1'b1, 16'h0456, 16'h1111, 16'h7FFF};
        tv[4] = '{1'b1, 1'b0, 16'h0456, 16'h0000, 16'h8000};
        tv[5] = '{1'b0, 1'b1, 16'hFFFF, 16'h8001, 16'h0011};
        tv[6] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h0010};
        tv[7] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000};

        RST         = 1'b0;
        if_addr_i   = 16'h0000;
        mem_rd_i    = 1'b0;
        mem_wr_i    = 1'b0;
        mem_addr_i  = 16'h0000;
        mem_wdata_i = 16'h0000;

        // Reset state while reset is held.
        repeat (3) @(negedge CLK);
        #1;
        check("rst_ce_n", sram_ce_n_o, 1);
        check("rst_oe_n", sram_oe_n_o, 1);
        check("rst_we_n", sram_we_n_o, 1);
        check("rst_instr", if_instr_o, NOP);
        check("rst_valid", if_valid_o, 0);
        check("rst_done", mem_done_o, 0);
        check("rst_rdata", mem_rdata_o, 0);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("rel_ce_n", sram_ce_n_o, 0);
        check("rel_stall", stall_pc_o, 0);

        // Fetch stream: each word appears the cycle after its address.
        for (int i = 0; i <= 6; i++) begin
            @(negedge CLK);
            if (i < 6) if_addr_i = fv[i].addr;
            #1;
            check("fetch_stall", stall_pc_o, 0);
            if (i < 6) check("fetch_addr", sram_addr_o, {2'b00, fv[i].addr});
            if (i > 0) begin
                check("fetch_valid", if_valid_o, 1);
                check("fetch_instr", if_instr_o, fv[i-1].word);
            end
        end

        // Table of data accesses, including read+write priority.
        foreach (tv[i]) do_txn(tv[i].rd, tv[i].wr, tv[i].addr, tv[i].wdata, tv[i].faddr);

        // Back-to-back loads with mem_rd_i never dropped: period of three
        // cycles, with exactly one fetch update between DREAD cycles.
        b2b_addr[0] = 16'h0123;
        b2b_addr[1] = 16'h8000;
        b2b_addr[2] = 16'h0456;
        @(negedge CLK);
        if_addr_i  = 16'h0010;
        mem_rd_i   = 1'b1;
        mem_addr_i = b2b_addr[0];
        #1;
        check("b2b_accept_stall", stall_pc_o, 1);
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK);
            #1;
            case (c % 3)
                1: begin
                    check("b2b_dread_oe_n", sram_oe_n_o, 0);
                    check("b2b_dread_addr", sram_addr_o, {PAGE, b2b_addr[c/3]});
                    check("b2b_dread_valid", if_valid_o, 0);
                    check("b2b_dread_done", mem_done_o, 0);
                end
                2: begin
                    check("b2b_done", mem_done_o, 1);
                    check("b2b_rdata", mem_rdata_o, exp_word({PAGE, b2b_addr[c/3]}));
                    check("b2b_done_stall", stall_pc_o, 0);
                    check("b2b_done_valid", if_valid_o, 0);
                    if (c < 8) mem_addr_i = b2b_addr[c/3 + 1];
                    else mem_rd_i = 1'b0;
                end
                default: begin
                    check("b2b_fetch_valid", if_valid_o, 1);
                    check("b2b_fetch_instr", if_instr_o, 16'h4A05);
                    check("b2b_accept2_stall", stall_pc_o, 1);
                    check("b2b_accept2_done", mem_done_o, 0);
                end
            endcase
        end
        @(negedge CLK);
        #1;
        check("b2b_tail_valid", if_valid_o, 1);

        // Reset asserted in the middle of the write pulse.
        @(negedge CLK);
        mem_wr_i    = 1'b1;
        mem_addr_i  = 16'h0777;
        mem_wdata_i = 16'hF00F;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        check("abort_pulse_active", sram_we_n_o, 0);
        RST      = 1'b0;
        probe_en = 1'b1;
        #1;
        check("abort_we_n", sram_we_n_o, 1);
        check("abort_ce_n", sram_ce_n_o, 1);
        check("abort_oe_n", sram_oe_n_o, 1);
        check("abort_bus_released", sram_data_io, 16'h0000);
        mem_wr_i = 1'b0;
        @(negedge CLK);
        #1;
        check("abort_hold_bus", sram_data_io, 16'h0000);
        RST      = 1'b1;
        probe_en = 1'b0;
        if_addr_i = 16'hFFFF;
        #1;
        check("abort_rel_stall", stall_pc_o, 0);
        check("abort_rel_oe_n", sram_oe_n_o, 0);
        check("abort_rel_instr", if_instr_o, NOP);
        check("abort_rel_valid", if_valid_o, 0);
        check("abort_rel_done", mem_done_o, 0);
        @(negedge CLK);
        #1;
        check("abort_fetch_valid", if_valid_o, 1);
        check("abort_fetch_instr", if_instr_o, 16'hABCD);
        check("abort_no_resume", sram_we_n_o, 1);

        // Random traffic over a small address pool so loads revisit stores.
        for (int n = 0; n < 60; n++) begin
            int unsigned op;
            logic [15:0] addr;
            op   = $urandom_range(0, 3);
            addr = 16'($urandom_range(0, 15) * 16'h1111);
            do_txn((op == 0) || (op == 3), (op == 1) || (op == 2) || (op == 3) ? (op != 0 && op != 3) || (op == 3 && $urandom_range(0, 1) == 1) : 1'b0,
                   addr, 16'($urandom), 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
